alu_exec_unit: RTL and testbench

//  Consumer end of the reservation-station issue interface. Accepts one ready

---
 rtl/alu_exec_unit.sv | 156 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit: input FIFO fed by the reservation station, head evaluated
// combinationally and registered onto the ALU common data bus keyed by ROB id.
module alu_exec_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic [4:0]    rob_q [DEPTH];
    logic [4:0]    rob_d [DEPTH];
    logic [6:0]    typ_q [DEPTH];
    logic [6:0]    typ_d [DEPTH];
    logic [3:0]    op_q  [DEPTH];
    logic [3:0]    op_d  [DEPTH];
    logic [31:0]   v1_q  [DEPTH];
    logic [31:0]   v1_d  [DEPTH];
    logic [31:0]   v2_q  [DEPTH];
    logic [31:0]   v2_d  [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          cdb_ready_q, cdb_ready_d;
    logic [4:0]    cdb_rob_q, cdb_rob_d;
    logic [31:0]   cdb_value_q, cdb_value_d;

    logic          push, pop, taken;
    logic [31:0]   res, hv1, hv2;
    logic [6:0]    htyp;
    logic [3:0]    hop;
    logic [4:0]    sh;

    // Issue acceptance looks only at registered occupancy, never at the same-cycle pop.
    assign _alu_full   = rdy_in && !_clear && (count_q < CW'(DEPTH));
    assign push        = _alu_ready && _alu_full;
    assign pop         = rdy_in && !_clear && (count_q != '0);
    assign _cdb_ready  = cdb_ready_q;
    assign _cdb_rob_id = cdb_rob_q;
    assign _cdb_value  = cdb_value_q;

    assign htyp = typ_q[rd_q];
    assign hop  = op_q[rd_q];
    assign hv1  = v1_q[rd_q];
    assign hv2  = v2_q[rd_q];
    assign sh   = hv2[4:0];

    always_comb begin
        res   = hv1 + hv2;
        taken = 1'b0;
        if (htyp == OP_R || htyp == OP_I) begin
            case (hop[2:0])
                3'b000: res = (htyp == OP_R && hop[3]) ? hv1 - hv2 : hv1 + hv2;
                3'b001: res = hv1 << sh;
                3'b010: res = {31'b0, $signed(hv1) < $signed(hv2)};
                3'b011: res = {31'b0, hv1 < hv2};
                3'b100: res = hv1 ^ hv2;
                3'b101: res = hop[3] ? 32'($signed(hv1) >>> sh) : hv1 >> sh;
                3'b110: res = hv1 | hv2;
                default: res = hv1 & hv2;
            endcase
        end else if (htyp == OP_B) begin
            case (hop[2:0])
                3'b000: taken = (hv1 == hv2);
                3'b001: taken = (hv1 != hv2);
                3'b100: taken = ($signed(hv1) < $signed(hv2));
                3'b101: taken = ($signed(hv1) >= $signed(hv2));
                3'b110: taken = (hv1 < hv2);
                3'b111: taken = (hv1 >= hv2);
                default: taken = 1'b0;
            endcase
            res = {31'b0, taken};
        end
    end

    always_comb begin
        rob_d       = rob_q;
        typ_d       = typ_q;
        op_d        = op_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        cdb_ready_d = cdb_ready_q;
        cdb_rob_d   = cdb_rob_q;
        cdb_value_d = cdb_value_q;
        if (_clear) begin
            wr_d        = '0;
            rd_d        = '0;
            count_d     = '0;
            cdb_ready_d = 1'b0;
        end else if (rdy_in) begin
            if (push) begin
                rob_d[wr_q] = _alu_rob_id;
                typ_d[wr_q] = _alu_type;
                op_d[wr_q]  = _alu_op;
                v1_d[wr_q]  = _alu_v1;
                v2_d[wr_q]  = _alu_v2;
                wr_d        = wr_q + 1'b1;
            end
            cdb_ready_d = pop;
            if (pop) begin
                rd_d        = rd_q + 1'b1;
                cdb_rob_d   = rob_q[rd_q];
                cdb_value_d = res;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
                typ_q[i] <= '0;
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
            end
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            cdb_ready_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            rob_q       <= rob_d;
            typ_q       <= typ_d;
            op_q        <= op_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            cdb_ready_q <= cdb_ready_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_value_q <= cdb_value_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, hand sequences for full/clear/
// pause/reset, then random traffic against a queue-based reference model.
module tb_alu_exec_unit;
    localparam int DEPTH = 4;
    localparam logic [6:0] TR = 7'b0110011;
    localparam logic [6:0] TI = 7'b0010011;
    localparam logic [6:0] TB = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, vld;
    logic [4:0]  rob;
    logic [6:0]  typ;
    logic [3:0]  op;
    logic [31:0] v1, v2;
    logic        full, cdb_rdy;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_val;

    alu_exec_unit #(.DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clr),
        ._alu_ready(vld), ._alu_rob_id(rob), ._alu_type(typ), ._alu_op(op),
        ._alu_v1(v1), ._alu_v2(v2), ._alu_full(full),
        ._cdb_ready(cdb_rdy), ._cdb_rob_id(cdb_rob), ._cdb_value(cdb_val)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rob; logic [31:0] val; } ent_t;
    ent_t        mq[$];
    logic        e_rdy;
    logic [4:0]  e_rob;
    logic [31:0] e_val;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics written straight from the instruction table.
    function automatic logic [31:0] ref_eval(input logic [6:0] t, input logic [3:0] o,
                                             input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic signed [31:0] sa, sb, sr;
        s  = b % 32;
        sa = a;
        sb = b;
        if (t == TR || t == TI) begin
            case (o[2:0])
                3'd0: return (t == TR && o[3]) ? a - b : a + b;
                3'd1: return a << s;
                3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: begin
                    sr = sa >>> s;
                    return o[3] ? sr : a >> s;
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        if (t == TB) begin
            case (o[2:0])
                3'd0: return 32'(a == b);
                3'd1: return 32'(a != b);
                3'd4: return 32'(sa < sb);
                3'd5: return 32'(sa >= sb);
                3'd6: return 32'(a < b);
                3'd7: return 32'(a >= b);
                default: return 32'd0;
            endcase
        end
        return a + b;
    endfunction

    task automatic model_reset();
        mq.delete();
        e_rdy = 1'b0;
        e_rob = '0;
        e_val = '0;
    endtask

    // One clock: drive at negedge, check full, advance model at posedge, check CDB.
    task automatic cycle(input logic r, input logic c, input logic v, input logic [4:0] rb,
                         input logic [6:0] t, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        logic f;
        ent_t e;
        rdy = r; clr = c; vld = v; rob = rb; typ = t; op = o; v1 = a; v2 = b;
        f = r && !c && (mq.size() < DEPTH);
        #1 chk("alu_full", 32'(full), 32'(f));
        @(posedge clk);
        if (c) begin
            mq.delete();
            e_rdy = 1'b0;
        end else if (r) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                e_rdy = 1'b1; e_rob = e.rob; e_val = e.val;
            end else begin
                e_rdy = 1'b0;
            end
            if (v && f) begin
                e.rob = rb; e.val = ref_eval(t, o, a, b);
                mq.push_back(e);
            end
        end
        @(negedge clk);
        chk("cdb_ready", 32'(cdb_rdy), 32'(e_rdy));
        chk("cdb_rob", 32'(cdb_rob), 32'(e_rob));
        chk("cdb_value", cdb_val, e_val);
    endtask

    task automatic idle(input logic r);
        cycle(r, 1'b0, 1'b0, 5'd0, TR, 4'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        logic [6:0] t; logic [3:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
    } vec_t;
    vec_t vt[12];

    initial begin
        vt[0]  = '{TR, 4'b0000, 32'd7, 32'd5, 32'd12};
        vt[1]  = '{TR, 4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF};
        vt[2]  = '{TR, 4'b1101, 32'h80000000, 32'h24, 32'hF8000000};
        vt[3]  = '{TI, 4'b1000, 32'd1, 32'd2, 32'd3};
        vt[4]  = '{TB, 4'b0100, 32'hFFFFFFFF, 32'd1, 32'd1};
        vt[5]  = '{TB, 4'b0110, 32'hFFFFFFFF, 32'd1, 32'd0};
        vt[6]  = '{TR, 4'b0101, 32'h80000000, 32'd4, 32'h08000000};
        vt[7]  = '{TR, 4'b0001, 32'd3, 32'd33, 32'd6};
        vt[8]  = '{TR, 4'b0010, 32'hFFFFFFFE, 32'd1, 32'd1};
        vt[9]  = '{TR, 4'b0011, 32'hFFFFFFFE, 32'd1, 32'd0};
        vt[10] = '{TB, 4'b0010, 32'd5, 32'd5, 32'd0};
        vt[11] = '{7'b0000011, 4'b1111, 32'd10, 32'd20, 32'd30};

        rst = 1'b1; rdy = 1'b1; clr = 1'b0; vld = 1'b0;
        rob = '0; typ = '0; op = '0; v1 = '0; v2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cdb_ready", 32'(cdb_rdy), 32'd0);
        chk("reset_cdb_rob", 32'(cdb_rob), 32'd0);
        chk("reset_cdb_value", cdb_val, 32'd0);
        chk("reset_full", 32'(full), 32'd1);
        @(negedge clk);

        // Directed table: push one, one idle edge, result must be on the CDB.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 5'(i + 3), vt[i].t, vt[i].o, vt[i].a, vt[i].b);
            idle(1'b1);
            chk("vec_ready", 32'(cdb_rdy), 32'd1);
            chk("vec_rob", 32'(cdb_rob), 32'(i + 3));
            chk("vec_value", cdb_val, vt[i].exp);
        end
        idle(1'b1);
        chk("drain_ready", 32'(cdb_rdy), 32'd0);

        // Paused issue is blocked, then DEPTH back-to-back pushes come out in order.
        cycle(1'b0, 1'b0, 1'b1, 5'd9, TR, 4'd0, 32'd1, 32'd1);
        chk("paused_no_push", 32'(cdb_rdy), 32'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 5'(k), TR, 4'd0, 32'(k), 32'd100);
            if (k > 1) chk("b2b_rob", 32'(cdb_rob), 32'(k - 1));
        end
        idle(1'b1);
        chk("b2b_last_rob", 32'(cdb_rob), 32'd4);
        chk("b2b_last_val", cdb_val, 32'd104);
        idle(1'b1);

        // Flush drops rob 6; rob 7 afterwards takes the normal two edges.
        cycle(1'b1, 1'b0, 1'b1, 5'd5, TI, 4'd0, 32'd5, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 5'd6, TI, 4'd0, 32'd6, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 5'd8, TI, 4'd0, 32'd8, 32'd0);
        chk("clear_ready", 32'(cdb_rdy), 32'd0);
        idle(1'b1);
        chk("clear_no_rob6", 32'(cdb_rdy), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 5'd7, TI, 4'd0, 32'd7, 32'd0);
        idle(1'b1);
        chk("post_clear_rob", 32'(cdb_rob), 32'd7);
        chk("post_clear_val", cdb_val, 32'd7);

        // Pause with entries queued: outputs frozen, then resume in order.
        cycle(1'b1, 1'b0, 1'b1, 5'd10, TR, 4'd0, 32'd10, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 5'd11, TR, 4'd0, 32'd11, 32'd0);
        repeat (3) begin
            idle(1'b0);
            chk("pause_frozen_rob", 32'(cdb_rob), 32'd10);
        end
        idle(1'b1);
        chk("resume_rob", 32'(cdb_rob), 32'd11);
        chk("resume_val", cdb_val, 32'd11);

        // Async reset mid-stream.
        cycle(1'b1, 1'b0, 1'b1, 5'd12, TR, 4'd0, 32'd1, 32'd2);
        cycle(1'b1, 1'b0, 1'b1, 5'd13, TR, 4'd0, 32'd1, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(cdb_rdy), 32'd0);
        chk("async_rst_rob", 32'(cdb_rob), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] t;
            case ($urandom_range(0, 5))
                0, 1: t = TR;
                2, 3: t = TI;
                4: t = TB;
                default: t = 7'($urandom);
            endcase
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0, 5'($urandom), t, 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
